// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: sizing and shared ROB/CDB types for the Tomasulo core.
`ifndef RO_BUFFER_ENTRIES
`define RO_BUFFER_ENTRIES 8
`endif
`ifndef NUM_CDB_ENTRIES
`define NUM_CDB_ENTRIES 4
`endif
package reorder_buffer_pkg;
    localparam int ROB_ENTRIES = `RO_BUFFER_ENTRIES;
    localparam int NUM_CDB = `NUM_CDB_ENTRIES;
    localparam int XLEN = 32;
    localparam int TAG_W = $clog2(ROB_ENTRIES);
    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef struct packed {
        logic valid;
        logic ready;
        logic [4:0] rd;
        logic [XLEN-1:0] value;
    } rob_entry_t;
    typedef struct packed {
        rob_tag_t tag;
        logic [XLEN-1:0] value;
    } cdb_entry_t;
    typedef cdb_entry_t [NUM_CDB-1:0] cdb_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: decoder allocation, CDB broadcast, RS readout and commit bundle.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;
    logic flush;
    logic alloc_valid;
    logic [4:0] alloc_rd;
    rob_tag_t alloc_tag;
    logic rob_full;
    logic rob_empty;
    logic [NUM_CDB-1:0] cdb_valid;
    cdb_t cdb;
    logic [ROB_ENTRIES-1:0][XLEN-1:0] rob_reg_vals;
    logic [ROB_ENTRIES-1:0] rob_commit_arr;
    logic commit_valid;
    logic [4:0] commit_rd;
    logic [XLEN-1:0] commit_value;
    rob_tag_t commit_tag;
    modport master (
        output flush, alloc_valid, alloc_rd, cdb_valid, cdb,
        input alloc_tag, rob_full, rob_empty, rob_reg_vals, rob_commit_arr,
        input commit_valid, commit_rd, commit_value, commit_tag
    );
    modport slave (
        input flush, alloc_valid, alloc_rd, cdb_valid, cdb,
        output alloc_tag, rob_full, rob_empty, rob_reg_vals, rob_commit_arr,
        output commit_valid, commit_rd, commit_value, commit_tag
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB; allocates tags, captures CDB results, retires in order.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic clk,
    input logic rst,
    reorder_buffer_if.slave bus
);
    rob_entry_t [ROB_ENTRIES-1:0] entry, nxt;
    rob_tag_t head, tail;
    logic [TAG_W:0] count;
    logic do_alloc, do_commit;
    assign bus.rob_full = count == (TAG_W+1)'(ROB_ENTRIES);
    assign bus.rob_empty = count == '0;
    assign bus.alloc_tag = tail;
    assign do_commit = entry[head].valid && entry[head].ready;
    assign do_alloc = bus.alloc_valid && !bus.rob_full;
    assign bus.commit_valid = do_commit;
    assign bus.commit_rd = entry[head].rd;
    assign bus.commit_value = entry[head].value;
    assign bus.commit_tag = head;
    for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_out
        assign bus.rob_reg_vals[i] = entry[i].value;
        assign bus.rob_commit_arr[i] = entry[i].ready;
    end
    // Lanes scanned high to low so the lowest matching lane overwrites last and wins.
    always_comb begin
        nxt = entry;
        for (int j = NUM_CDB - 1; j >= 0; j--)
            if (bus.cdb_valid[j] && entry[bus.cdb[j].tag].valid && !entry[bus.cdb[j].tag].ready) begin
                nxt[bus.cdb[j].tag].value = bus.cdb[j].value;
                nxt[bus.cdb[j].tag].ready = 1'b1;
            end
        if (do_commit) begin
            nxt[head].valid = 1'b0;
            nxt[head].ready = 1'b0;
        end
        if (do_alloc) nxt[tail] = '{valid: 1'b1, ready: 1'b0, rd: bus.alloc_rd, value: '0};
    end
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            entry <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            entry <= nxt;
            head <= head + rob_tag_t'(do_commit);
            tail <= tail + rob_tag_t'(do_alloc);
            count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plus random stimulus against a program-order queue model with a commit scoreboard.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;
    typedef struct {
        rob_tag_t tag;
        logic [4:0] rd;
    } flight_t;
    typedef struct {
        rob_tag_t tag;
        logic [4:0] rd;
        logic [XLEN-1:0] value;
    } commit_t;
    logic clk = 0;
    logic rst = 1;
    reorder_buffer_if bus ();
    reorder_buffer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int n_vec = 0;
    int n_err = 0;
    flight_t q[$];
    commit_t exp_q[$];
    logic [XLEN-1:0] mvals[ROB_ENTRIES];
    logic [ROB_ENTRIES-1:0] mrdy = '0;
    rob_tag_t ntag = '0;
    task automatic chk(string name, logic [ROB_ENTRIES*XLEN-1:0] act, logic [ROB_ENTRIES*XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        if (exp_q.size() > 0) begin
            commit_t e;
            e = exp_q.pop_front();
            chk("commit_valid", bus.commit_valid, 1);
            chk("commit_tag", bus.commit_tag, e.tag);
            chk("commit_rd", bus.commit_rd, e.rd);
            chk("commit_value", bus.commit_value, e.value);
        end else
            chk("commit_valid_idle", bus.commit_valid, 0);
    end
    task automatic model_edge();
        logic [ROB_ENTRIES-1:0] inflight, pre, got;
        bit commit, full;
        if (rst || bus.flush) begin
            q.delete();
            mrdy = '0;
            foreach (mvals[i]) mvals[i] = '0;
            ntag = '0;
            return;
        end
        commit = q.size() > 0 && mrdy[q[0].tag];
        full = q.size() == ROB_ENTRIES;
        inflight = '0;
        foreach (q[i]) inflight[q[i].tag] = 1'b1;
        pre = mrdy;
        got = '0;
        for (int j = 0; j < NUM_CDB; j++) begin
            rob_tag_t t;
            t = bus.cdb[j].tag;
            if (bus.cdb_valid[j] && inflight[t] && !pre[t] && !got[t]) begin
                got[t] = 1'b1;
                mvals[t] = bus.cdb[j].value;
                mrdy[t] = 1'b1;
            end
        end
        if (commit) begin
            mrdy[q[0].tag] = 1'b0;
            void'(q.pop_front());
        end
        if (bus.alloc_valid && !full) begin
            q.push_back('{tag: ntag, rd: bus.alloc_rd});
            mvals[ntag] = '0;
            mrdy[ntag] = 1'b0;
            ntag++;
        end
    endtask
    task automatic tick();
        logic [ROB_ENTRIES-1:0][XLEN-1:0] ev;
        @(posedge clk);
        model_edge();
        #1;
        if (!rst && q.size() > 0 && mrdy[q[0].tag])
            exp_q.push_back('{tag: q[0].tag, rd: q[0].rd, value: mvals[q[0].tag]});
        foreach (mvals[i]) ev[i] = mvals[i];
        chk("alloc_tag", bus.alloc_tag, ntag);
        chk("rob_full", bus.rob_full, q.size() == ROB_ENTRIES);
        chk("rob_empty", bus.rob_empty, q.size() == 0);
        chk("rob_commit_arr", bus.rob_commit_arr, mrdy);
        chk("rob_reg_vals", bus.rob_reg_vals, ev);
        bus.alloc_valid = 0;
        bus.cdb_valid = '0;
        bus.flush = 0;
    endtask
    task automatic lane(int j, rob_tag_t t, logic [XLEN-1:0] v);
        bus.cdb_valid[j] = 1'b1;
        bus.cdb[j].tag = t;
        bus.cdb[j].value = v;
    endtask
    task automatic alloc(logic [4:0] rd);
        bus.alloc_valid = 1;
        bus.alloc_rd = rd;
    endtask
    initial begin
        foreach (mvals[i]) mvals[i] = '0;
        bus.flush = 0;
        bus.alloc_valid = 0;
        bus.alloc_rd = '0;
        bus.cdb_valid = '0;
        bus.cdb = '0;
        tick();
        tick();
        rst = 0;
        tick();
        for (int i = 5; i <= 7; i++) begin alloc(5'(i)); tick(); end
        lane(0, 1, 32'hAA); tick();
        tick();
        lane(1, 0, 32'h55); tick();
        repeat (3) tick();
        bus.flush = 1; tick();
        for (int i = 0; i < ROB_ENTRIES + 1; i++) begin alloc(5'(i + 1)); tick(); end
        alloc(9); lane(0, 0, 32'h1234); tick();
        alloc(9); tick();
        alloc(9); tick();
        bus.flush = 1; tick();
        for (int i = 0; i < 4; i++) begin alloc(5'(10 + i)); tick(); end
        lane(0, 3, 32'h11); lane(2, 3, 32'h22); lane(1, 6, 32'hDEAD); tick();
        tick();
        alloc(20); lane(3, 2, 32'h77); bus.flush = 1; tick();
        tick();
        alloc(0); tick();
        lane(0, 0, 32'hCAFE); tick();
        repeat (2) tick();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) < 70) alloc(5'($urandom));
            for (int j = 0; j < NUM_CDB; j++)
                if ($urandom_range(99) < 35)
                    lane(j, (q.size() > 0 && $urandom_range(9) < 8) ? q[$urandom_range(q.size() - 1)].tag : rob_tag_t'($urandom), $urandom);
            if ($urandom_range(99) < 2) bus.flush = 1;
            tick();
        end
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
